// File: rtl/karp_mem_pkg.sv
// Shared types for the memory access controller: FSM state encoding and
// port index constants used by the top level and the round-robin arbiter.
package karp_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2,
      ST_CLEAR  = 2'd3
   } mem_state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester round-robin arbiter (fetch vs data). The pointer remembers
// the last granted port and only moves when the grant is actually taken.
module mem_rr_arb
   import karp_mem_pkg::*;
(
   input  logic clk,
   input  logic clr_n,
   input  logic f_req,
   input  logic d_req,
   input  logic take,
   output logic gnt_any,
   output logic gnt_port
);

   logic last_port;

   always_comb begin
      gnt_any = f_req | d_req;
      if (f_req && d_req) begin
         gnt_port = ~last_port;
      end else if (d_req) begin
         gnt_port = PORT_DATA;
      end else begin
         gnt_port = PORT_FETCH;
      end
   end

   // Reset value "data was last" makes fetch win the first contested grant.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         last_port <= PORT_DATA;
      end else if (take && gnt_any) begin
         last_port <= gnt_port;
      end
   end

endmodule

// File: rtl/memory_access_controller.sv
// Two-port (fetch read-only, data read/write) controller for a single-port RAM
// with whole-memory clear. Define MEMCTL_PERF_CNT_EN to add per-port grant counters.
module memory_access_controller
   import karp_mem_pkg::*;
#(
   parameter int n = 8,
   parameter int m = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         f_req,
   input  logic [n-1:0] f_addr,
   output logic         f_ack,
   output logic [m-1:0] f_rdata,
   input  logic         d_req,
   input  logic         d_rw,
   input  logic [n-1:0] d_addr,
   input  logic [m-1:0] d_wdata,
   output logic         d_ack,
   output logic [m-1:0] d_rdata,
`ifdef MEMCTL_PERF_CNT_EN
   output logic [15:0]  f_grants,
   output logic [15:0]  d_grants,
`endif
   input  logic         clr_req,
   output logic         busy,
   output logic [n-1:0] mem_addr,
   output logic         mem_en,
   output logic         mem_rw,
   output logic         mem_clr,
   output logic [m-1:0] mem_wdata,
   output logic         mem_oe,
   input  logic [m-1:0] mem_rdata,
   output mem_state_t   state_dbg
);

   // Handshake: a port holds req (level) until it sees a one-cycle ack; the
   // request is captured at grant, so later input changes do not affect it.
   mem_state_t   state, state_nxt;
   logic         pend_clr, clr_hit, take;
   logic         arb_any, arb_port;
   logic         gnt_port, lat_rw;
   logic [n-1:0] lat_addr;
   logic [m-1:0] lat_wdata;
   logic         in_access, in_resp;

   mem_rr_arb u_arb (
      .clk      (clk),
      .clr_n    (clr_n),
      .f_req    (f_req),
      .d_req    (d_req),
      .take     (take),
      .gnt_any  (arb_any),
      .gnt_port (arb_port)
   );

   assign clr_hit = pend_clr | clr_req;

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clr_hit) begin
               state_nxt = ST_CLEAR;
            end else if (arb_any) begin
               state_nxt = ST_ACCESS;
               take      = 1'b1;
            end
         end
         ST_ACCESS: state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         ST_CLEAR:  state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= ST_IDLE;
         pend_clr  <= 1'b0;
         gnt_port  <= PORT_FETCH;
         lat_rw    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         f_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         state <= state_nxt;
         // A clear seen in IDLE is served immediately; anywhere else it waits.
         if (state == ST_IDLE && clr_hit) begin
            pend_clr <= 1'b0;
         end else if (clr_req) begin
            pend_clr <= 1'b1;
         end
         if (take) begin
            gnt_port  <= arb_port;
            lat_addr  <= (arb_port == PORT_DATA) ? d_addr : f_addr;
            lat_rw    <= (arb_port == PORT_DATA) & d_rw;
            lat_wdata <= d_wdata;
         end
         if (state == ST_ACCESS && !lat_rw) begin
            if (gnt_port == PORT_FETCH) begin
               f_rdata <= mem_rdata;
            end else begin
               d_rdata <= mem_rdata;
            end
         end
      end
   end

   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);

   always_comb begin
      mem_en    = in_access;
      mem_rw    = in_access & lat_rw;
      mem_oe    = in_access & lat_rw;
      mem_addr  = in_access ? lat_addr : '0;
      mem_wdata = (in_access && lat_rw) ? lat_wdata : '0;
      mem_clr   = (state == ST_CLEAR);
      busy      = (state != ST_IDLE);
      f_ack     = in_resp & (gnt_port == PORT_FETCH);
      d_ack     = in_resp & (gnt_port == PORT_DATA);
      state_dbg = state;
   end

`ifdef MEMCTL_PERF_CNT_EN
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         f_grants <= '0;
         d_grants <= '0;
      end else begin
         if (f_ack && f_grants != 16'hFFFF) f_grants <= f_grants + 16'd1;
         if (d_ack && d_grants != 16'hFFFF) d_grants <= d_grants + 16'd1;
      end
   end
`endif

endmodule

// File: doc/memory_access_controller.md
MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter n, default 8: address width in bits; RAM depth is 2**n words.
REQ-002 Parameter m, default 16: data word width in bits.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 clr_n  in  1  reset, asynchronous, active-low.
REQ-005 f_req  in  1  fetch-port request, level, held until f_ack.
REQ-006 f_addr  in  n  fetch-port address; fetch port is read-only.
REQ-007 f_ack  out  1  one-cycle pulse: f_rdata valid.
REQ-008 f_rdata  out  m  fetch read data, registered, held until next fetch ack.
REQ-009 d_req  in  1  data-port request, level, held until d_ack.
REQ-010 d_rw  in  1  data-port direction: 0 read, 1 write.
REQ-011 d_addr  in  n  data-port address.
REQ-012 d_wdata  in  m  data-port write data.
REQ-013 d_ack  out  1  one-cycle pulse: access complete; d_rdata valid for reads.
REQ-014 d_rdata  out  m  data read data, registered, held until next data read ack.
REQ-015 clr_req  in  1  one-cycle pulse: request whole-memory clear.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 mem_addr  out  n  RAM address.
REQ-018 mem_en  out  1  RAM enable.
REQ-019 mem_rw  out  1  RAM direction: 0 read, 1 write.
REQ-020 mem_clr  out  1  RAM synchronous clear.
REQ-021 mem_wdata  out  m  write data to the MDR line driver.
REQ-022 mem_oe  out  1  drives mem_wdata onto the shared MDR line; high only during a write access.
REQ-023 mem_rdata  in  m  MDR line, sampled during read accesses.

Function
REQ-024 FSM states: IDLE, ACCESS, RESP, CLEAR.
REQ-025 IDLE: a pending clr_req goes to CLEAR; otherwise any req goes to ACCESS; otherwise stay in IDLE.
REQ-026 Clear priority: clr_req beats both ports; a clr_req pulse arriving outside IDLE is latched and served at the next IDLE.
REQ-027 Grant on IDLE->ACCESS: latch winner, address, direction and write data; later changes on port inputs are ignored until ack.
REQ-028 Arbitration:
- only one port requesting: that port wins;
- both requesting: round-robin, the port not granted last wins;
- pointer reset value: data was last, so fetch wins first.
REQ-029 ACCESS lasts exactly one cycle: mem_en=1, mem_addr/mem_rw from latch; write: mem_oe=1, RAM writes at closing edge; read: mem_rdata captured at closing edge.
REQ-030 RESP lasts one cycle: ack pulse to the granted port only; next state IDLE.
REQ-031 Latency: req high in IDLE at cycle t -> ACCESS t+1 -> ack t+2. Minimum repeat interval per access is 3 cycles.
REQ-032 CLEAR lasts one cycle with mem_clr=1 and mem_en=0; next state IDLE; no ack is generated.
REQ-033 A req dropped before grant is not served; a req dropped after grant still completes and is acked.
REQ-034 Outside ACCESS: mem_en=0 and mem_oe=0. Outside CLEAR: mem_clr=0.

Reset
REQ-035 clr_n low: FSM returns to IDLE immediately, even mid-access, and no ack is produced for the aborted access.
REQ-036 clr_n low: every output is 0 (f_rdata, d_rdata, mem_* and busy), the pending-clear latch is cleared, and the round-robin pointer resets.

Configuration
REQ-037 Macro MEMCTL_PERF_CNT_EN:
- defined: adds outputs f_grants and d_grants, 16-bit each, saturating at 16'hFFFF; each increments on its port's ack; both reset to 0.
- undefined: neither port nor counter exists; all other behaviour is unchanged.

Structure
REQ-038 Shared package karp_mem_pkg holds the FSM state enum and the port index constants PORT_FETCH=0 and PORT_DATA=1.
REQ-039 Sub-module mem_rr_arb: 2-requester round-robin arbiter; it holds the pointer and updates it on grant.

Verification
REQ-040 f_req at addr 0x10 holding 0xBEEF -> f_ack at t+2, f_rdata=0xBEEF.
REQ-041 d write 0x1234 to 0x05, then f read of 0x05 -> f_rdata=0x1234; mem_oe high only during the write's ACCESS cycle.
REQ-042 f_req and d_req held together from reset -> grant order fetch, data, fetch, data; acks never coincide.
REQ-043 clr_req pulse during a data ACCESS -> access acked first, then one mem_clr cycle; a later read of any address returns 0.
REQ-044 clr_n low during ACCESS -> no ack, all outputs 0; after release, a held req is served normally.
REQ-045 With MEMCTL_PERF_CNT_EN: 5 fetch and 3 data accesses -> f_grants=5, d_grants=3.
